// File: rtl/sayeh_control_unit.sv
// sayeh_control_unit
//   Multi-cycle control FSM for the SAYEH CPU. It fetches a 16-bit word into IR,
//   decodes it, and drives every datapath, memory and IO strobe. A short
//   instruction may carry a second short instruction in IR[7:0]. That second
//   (shadow) instruction is run from the same fetch, with Shadow=1.
// Ports
//   clk, External_Reset         : rising-edge clock, synchronous active-high reset
//   Instruction, Cout, Zout     : IR contents and status flags from the datapath
//   MemDataReady                : memory/IO completion for the current strobe
//   ReadMem/WriteMem/ReadIO/WriteIO, Halted : external handshake and halt status
//   remaining outputs           : addressing-unit, ALU, register, bus and flag strobes
// Outputs are decoded from the registered state. Where the datapath has to react
// in the same cycle, the decode is also qualified by MemDataReady.
module sayeh_control_unit #(
   parameter int MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        External_Reset,
   input  logic [15:0] Instruction,
   input  logic        Cout,
   input  logic        Zout,
   input  logic        MemDataReady,
   output logic        ReadMem,
   output logic        WriteMem,
   output logic        ReadIO,
   output logic        WriteIO,
   output logic        Halted,
   output logic        ResetPC,
   output logic        PCplusI,
   output logic        PCplus1,
   output logic        RplusI,
   output logic        Rplus0,
   output logic        EnablePC,
   output logic        Rs_on_AddressUnitRSide,
   output logic        Rd_on_AddressUnitRSide,
   output logic        B15to0,
   output logic        AandB,
   output logic        AorB,
   output logic        notB,
   output logic        shlB,
   output logic        shrB,
   output logic        AaddB,
   output logic        AsubB,
   output logic        AmulB,
   output logic        AcmpB,
   output logic        RFLwrite,
   output logic        RFHwrite,
   output logic        WPreset,
   output logic        WPadd,
   output logic        IRload,
   output logic        SRload,
   output logic        Address_on_Databus,
   output logic        ALU_on_Databus,
   output logic        IR_on_LOpndBus,
   output logic        IR_on_HOpndBus,
   output logic        RFright_on_OpndBus,
   output logic        Cset,
   output logic        Creset,
   output logic        Zset,
   output logic        Zreset,
   output logic        Shadow
);

   typedef enum logic [2:0] {
      S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_INC, S_HALT
   } state_t;

   state_t      r_state;
   logic        r_shadow;
   logic [3:0]  r_op;
   logic [3:0]  r_sub;
   logic        r_low_nz;
   logic [15:0] r_wait;

   logic   w_short;
   logic   w_illegal_sh;
   logic   w_go_shadow;
   logic   w_timeout;
   state_t w_after;
   state_t w_exec_next;

   // Short instructions can be followed by a shadow instruction in the low byte.
   // A long opcode decoded from the low byte has no meaning there and runs as a nop.
   assign w_short      = ((r_op == 4'h0) && (r_sub <= 4'h6)) || ((r_op != 4'h0) && (r_op != 4'hF));
   assign w_illegal_sh = r_shadow && !w_short;
   assign w_go_shadow  = !r_shadow && w_short && r_low_nz;
   assign w_after      = w_go_shadow ? S_DECODE : S_INC;
   // A MEM_TIMEOUT of 0 disables the watchdog.
   assign w_timeout    = (MEM_TIMEOUT != 0) && !MemDataReady &&
                         (r_wait == 16'(MEM_TIMEOUT - 1));

   always_comb begin
      w_exec_next = w_after;
      if (!w_illegal_sh) begin
         case (r_op)
            4'h0: begin
               case (r_sub)
                  4'h1:             w_exec_next = S_HALT;
                  4'h7, 4'h8, 4'h9: w_exec_next = S_FETCH;   // PC already updated
                  default:          ;
               endcase
            end
            4'h2, 4'h3, 4'h4, 4'h5: w_exec_next = S_MEM;
            4'hF:    if (r_sub[1:0] == 2'b11) w_exec_next = S_FETCH;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (External_Reset) begin
         r_state  <= S_RST;
         r_shadow <= 1'b0;
         r_wait   <= '0;
      end else begin
         case (r_state)
            S_RST: begin
               r_state  <= S_FETCH;
               r_shadow <= 1'b0;
               r_wait   <= '0;
            end
            S_FETCH: begin
               r_shadow <= 1'b0;
               if (MemDataReady)   r_state <= S_DECODE;
               else if (w_timeout) r_state <= S_HALT;
               else                r_wait  <= r_wait + 16'd1;
            end
            S_DECODE: begin
               r_op     <= r_shadow ? Instruction[7:4] : Instruction[15:12];
               r_sub    <= r_shadow ? Instruction[3:0] : Instruction[11:8];
               r_low_nz <= |Instruction[7:0];
               r_wait   <= '0;
               r_state  <= S_EXEC;
            end
            S_EXEC: begin
               r_wait  <= '0;
               r_state <= w_exec_next;
               if (w_exec_next == S_DECODE) r_shadow <= 1'b1;
            end
            S_MEM: begin
               // Shadow stays put for the whole wait; it changes only once the transfer completes.
               if (MemDataReady) begin
                  r_state <= w_after;
                  if (w_go_shadow) r_shadow <= 1'b1;
               end else if (w_timeout) begin
                  r_state <= S_HALT;
               end else begin
                  r_wait <= r_wait + 16'd1;
               end
            end
            S_INC: begin
               r_shadow <= 1'b0;
               r_wait   <= '0;
               r_state  <= S_FETCH;
            end
            default: r_state <= S_HALT;
         endcase
      end
   end

   always_comb begin
      {ReadMem, WriteMem, ReadIO, WriteIO, Halted} = '0;
      {ResetPC, PCplusI, PCplus1, RplusI, Rplus0, EnablePC} = '0;
      {Rs_on_AddressUnitRSide, Rd_on_AddressUnitRSide} = '0;
      {B15to0, AandB, AorB, notB, shlB, shrB, AaddB, AsubB, AmulB, AcmpB} = '0;
      {RFLwrite, RFHwrite, WPreset, WPadd, IRload, SRload} = '0;
      {Address_on_Databus, ALU_on_Databus, IR_on_LOpndBus, IR_on_HOpndBus, RFright_on_OpndBus} = '0;
      {Cset, Creset, Zset, Zreset} = '0;
      Shadow = r_shadow && ((r_state == S_DECODE) || (r_state == S_EXEC) || (r_state == S_MEM));
      case (r_state)
         S_RST: {ResetPC, EnablePC, WPreset, Creset, Zreset} = '1;
         S_FETCH: begin
            ReadMem = 1'b1;
            IRload  = MemDataReady;
         end
         S_EXEC: begin
            if (!w_illegal_sh) begin
               case (r_op)
                  4'h0: begin
                     case (r_sub)
                        4'h2: Zset    = 1'b1;
                        4'h3: Zreset  = 1'b1;
                        4'h4: Cset    = 1'b1;
                        4'h5: Creset  = 1'b1;
                        4'h6: WPreset = 1'b1;
                        4'h7: {PCplusI, EnablePC} = '1;
                        4'h8: begin
                           PCplusI  = Zout;
                           PCplus1  = !Zout;
                           EnablePC = 1'b1;
                        end
                        4'h9: begin
                           PCplusI  = Cout;
                           PCplus1  = !Cout;
                           EnablePC = 1'b1;
                        end
                        4'hA:    WPadd = 1'b1;
                        default: ;
                     endcase
                  end
                  4'h1: {RFright_on_OpndBus, B15to0, ALU_on_Databus, RFLwrite, RFHwrite} = '1;
                  4'h6, 4'h7, 4'h8, 4'h9, 4'hA, 4'hB, 4'hC, 4'hD, 4'hE: begin
                     RFright_on_OpndBus = 1'b1;
                     SRload             = 1'b1;
                     AandB = (r_op == 4'h6);
                     AorB  = (r_op == 4'h7);
                     notB  = (r_op == 4'h8);
                     shlB  = (r_op == 4'h9);
                     shrB  = (r_op == 4'hA);
                     AaddB = (r_op == 4'hB);
                     AsubB = (r_op == 4'hC);
                     AmulB = (r_op == 4'hD);
                     AcmpB = (r_op == 4'hE);
                     // Compare only updates the status register.
                     if (r_op != 4'hE) {ALU_on_Databus, RFLwrite, RFHwrite} = '1;
                  end
                  4'hF: begin
                     case (r_sub[1:0])
                        2'b00: {IR_on_LOpndBus, B15to0, RFLwrite} = '1;
                        2'b01: {IR_on_HOpndBus, B15to0, RFHwrite} = '1;
                        2'b10: {PCplusI, Address_on_Databus, RFLwrite, RFHwrite} = '1;
                        default: {Rd_on_AddressUnitRSide, RplusI, EnablePC} = '1;
                     endcase
                  end
                  default: ;
               endcase
            end
         end
         S_MEM: begin
            Rs_on_AddressUnitRSide = 1'b1;
            Rplus0   = 1'b1;
            ReadMem  = (r_op == 4'h2);
            WriteMem = (r_op == 4'h3);
            ReadIO   = (r_op == 4'h4);
            WriteIO  = (r_op == 4'h5);
            if ((r_op == 4'h2) || (r_op == 4'h4)) begin
               RFLwrite = MemDataReady;
               RFHwrite = MemDataReady;
            end else begin
               {RFright_on_OpndBus, B15to0, ALU_on_Databus} = '1;
            end
         end
         S_INC: {PCplus1, EnablePC} = '1;
         S_HALT: Halted = 1'b1;
         default: ;
      endcase
   end

endmodule
